// File: rtl/trap_commit_unit.sv
// Writeback-side trap commit sequencer: turns a retiring exception, a pending
// interrupt or an mret into a series of machine-mode CSR writes over a single
// write port, updates the privilege level, then redirects the PC and flushes.
module trap_commit_unit #(
    parameter int XLEN         = 64,
    parameter bit MTVEC_VEC_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            except_wb_except,
    input  logic [XLEN-1:0] except_wb_epc,
    input  logic [XLEN-1:0] except_wb_ecause,
    input  logic [XLEN-1:0] except_wb_etval,
    input  logic            valid_wb,
    input  logic            mret_wb,
    input  logic            int_pending,
    input  logic [3:0]      int_code,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic [1:0]      priv_o,
    output logic            stall_pipe,
    output logic            flush_all,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_busy
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIRECT
    } state_t;

    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;

    state_t          state_q, state_d;
    logic [1:0]      priv_q, priv_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic            is_mret_q, is_mret_d;

    logic take_exc, take_int, take_mret;

    // Trigger decode, priority exception > interrupt > mret; bubbles never trap.
    always_comb begin
        take_exc  = valid_wb & except_wb_except;
        take_int  = int_pending & mstatus_i[3] & ~take_exc;
        take_mret = valid_wb & mret_wb & ~take_exc & ~take_int;
    end

    // State and latched trap context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            priv_q    <= 2'b11;
            epc_q     <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            priv_q    <= priv_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            tval_q    <= tval_d;
            mstatus_q <= mstatus_d;
            is_mret_q <= is_mret_d;
        end
    end

    // Next-state, CSR write sequencing and redirect outputs.
    always_comb begin
        logic [XLEN-1:0] st_wr;
        logic [XLEN-1:0] base;

        state_d        = state_q;
        priv_d         = priv_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        tval_d         = tval_q;
        mstatus_d      = mstatus_q;
        is_mret_d      = is_mret_q;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        stall_pipe     = 1'b0;
        flush_all      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        st_wr          = mstatus_q;
        base           = {mtvec_i[XLEN-1:2], 2'b00};

        case (state_q)
            IDLE: begin
                if (take_exc || take_int || take_mret) begin
                    stall_pipe = 1'b1;
                    flush_all  = 1'b1;
                    mstatus_d  = mstatus_i;
                end
                if (take_exc) begin
                    epc_d     = except_wb_epc;
                    cause_d   = except_wb_ecause;
                    tval_d    = except_wb_etval;
                    is_mret_d = 1'b0;
                    state_d   = W_EPC;
                end else if (take_int) begin
                    // The retiring instruction is not executed; it resumes at its own pc.
                    epc_d     = except_wb_epc;
                    cause_d   = {1'b1, {(XLEN-5){1'b0}}, int_code};
                    tval_d    = '0;
                    is_mret_d = 1'b0;
                    state_d   = W_EPC;
                end else if (take_mret) begin
                    is_mret_d = 1'b1;
                    state_d   = R_STATUS;
                end
            end
            W_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = {epc_q[XLEN-1:2], 2'b00};
                state_d   = W_CAUSE;
            end
            W_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = cause_q;
                state_d   = W_TVAL;
            end
            W_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MTVAL;
                csr_wdata = tval_q;
                state_d   = W_STATUS;
            end
            W_STATUS: begin
                st_wr[7]     = mstatus_q[3];
                st_wr[3]     = 1'b0;
                st_wr[12:11] = priv_q;
                csr_we       = 1'b1;
                csr_waddr    = ADDR_MSTATUS;
                csr_wdata    = st_wr;
                priv_d       = 2'b11;
                state_d      = REDIRECT;
            end
            R_STATUS: begin
                st_wr[3]     = mstatus_q[7];
                st_wr[7]     = 1'b1;
                st_wr[12:11] = 2'b00;
                csr_we       = 1'b1;
                csr_waddr    = ADDR_MSTATUS;
                csr_wdata    = st_wr;
                priv_d       = mstatus_q[12:11];
                state_d      = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                flush_all      = 1'b1;
                if (is_mret_q) begin
                    redirect_pc = mepc_i;
                end else if (cause_q[XLEN-1] && MTVEC_VEC_EN && (mtvec_i[1:0] == 2'b01)) begin
                    redirect_pc = base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
                end else begin
                    redirect_pc = base;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            stall_pipe = 1'b1;
        end
    end

    assign priv_o    = priv_q;
    assign trap_busy = (state_q != IDLE);

endmodule

// File: tb/tb_trap_commit_unit.sv
// Directed bench for trap_commit_unit: reset, mret, exception, vectored
// interrupt, priority, bubble/busy and mid-sequence reset scenarios.
module tb_trap_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        except_wb_except;
    logic [63:0] except_wb_epc;
    logic [63:0] except_wb_ecause;
    logic [63:0] except_wb_etval;
    logic        valid_wb;
    logic        mret_wb;
    logic        int_pending;
    logic [3:0]  int_code;
    logic [63:0] mstatus_i;
    logic [63:0] mtvec_i;
    logic [63:0] mepc_i;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic [1:0]  priv_o;
    logic        stall_pipe;
    logic        flush_all;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        trap_busy;

    int checks   = 0;
    int failures = 0;

    trap_commit_unit #(.XLEN(64), .MTVEC_VEC_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .except_wb_except(except_wb_except), .except_wb_epc(except_wb_epc),
        .except_wb_ecause(except_wb_ecause), .except_wb_etval(except_wb_etval),
        .valid_wb(valid_wb), .mret_wb(mret_wb),
        .int_pending(int_pending), .int_code(int_code),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .priv_o(priv_o), .stall_pipe(stall_pipe), .flush_all(flush_all),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_busy(trap_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [11:0] addr, input logic [63:0] data);
        chk({tag, "_we"}, 64'(csr_we), 64'd1);
        chk({tag, "_addr"}, 64'(csr_waddr), 64'(addr));
        chk({tag, "_data"}, csr_wdata, data);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        except_wb_except = 1'b0;
        valid_wb         = 1'b0;
        mret_wb          = 1'b0;
        int_pending      = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        except_wb_epc = '0; except_wb_ecause = '0; except_wb_etval = '0;
        int_code = '0; mstatus_i = '0; mtvec_i = '0; mepc_i = '0;

        // Reset state
        #12;
        chk("rst_priv", 64'(priv_o), 64'd3);
        chk("rst_we", 64'(csr_we), 64'd0);
        chk("rst_stall", 64'(stall_pipe), 64'd0);
        chk("rst_flush", 64'(flush_all), 64'd0);
        chk("rst_redir", 64'(redirect_valid), 64'd0);
        chk("rst_busy", 64'(trap_busy), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // mret: MPIE=1, MPP=0 -> MIE=1, MPIE=1, MPP=0, priv 0
        mstatus_i = 64'h80; mepc_i = 64'h8000_0400;
        valid_wb = 1'b1; mret_wb = 1'b1;
        #1;
        chk("mret_trig_stall", 64'(stall_pipe), 64'd1);
        chk("mret_trig_flush", 64'(flush_all), 64'd1);
        chk("mret_trig_we", 64'(csr_we), 64'd0);
        tick();
        idle_inputs();
        #1;
        chk_wr("mret_status", 12'h300, 64'h88);
        chk("mret_busy", 64'(trap_busy), 64'd1);
        tick();
        chk("mret_redir_v", 64'(redirect_valid), 64'd1);
        chk("mret_redir_pc", redirect_pc, 64'h8000_0400);
        chk("mret_redir_we", 64'(csr_we), 64'd0);
        chk("mret_priv", 64'(priv_o), 64'd0);
        tick();
        chk("mret_done_stall", 64'(stall_pipe), 64'd0);
        chk("mret_done_redir", 64'(redirect_valid), 64'd0);

        // Illegal instruction from priv 0, second exception during W_CAUSE ignored
        mstatus_i = 64'h8; mtvec_i = 64'h8000_1000;
        except_wb_except = 1'b1; valid_wb = 1'b1;
        except_wb_epc = 64'h8000_0010; except_wb_ecause = 64'd2; except_wb_etval = 64'h13;
        #1;
        chk("ill_trig_stall", 64'(stall_pipe), 64'd1);
        chk("ill_trig_flush", 64'(flush_all), 64'd1);
        tick();
        idle_inputs();
        #1;
        chk_wr("ill_epc", 12'h341, 64'h8000_0010);
        tick();
        except_wb_except = 1'b1; valid_wb = 1'b1;
        except_wb_epc = 64'h9000_0000; except_wb_ecause = 64'd7; except_wb_etval = 64'h55;
        #1;
        chk_wr("ill_cause", 12'h342, 64'd2);
        tick();
        idle_inputs();
        #1;
        chk_wr("ill_tval", 12'h343, 64'h13);
        tick();
        chk_wr("ill_status", 12'h300, 64'h80);
        tick();
        chk("ill_redir_v", 64'(redirect_valid), 64'd1);
        chk("ill_redir_pc", redirect_pc, 64'h8000_1000);
        chk("ill_priv", 64'(priv_o), 64'd3);
        chk("ill_redir_we", 64'(csr_we), 64'd0);
        tick();
        chk("ill_done_busy", 64'(trap_busy), 64'd0);
        chk("ill_done_stall", 64'(stall_pipe), 64'd0);

        // Vectored timer interrupt from priv 3
        mstatus_i = 64'h8; mtvec_i = 64'h8000_1001;
        except_wb_epc = 64'h8000_0200; int_pending = 1'b1; int_code = 4'd7;
        #1;
        chk("int_trig_stall", 64'(stall_pipe), 64'd1);
        tick();
        idle_inputs();
        #1;
        chk_wr("int_epc", 12'h341, 64'h8000_0200);
        tick();
        chk_wr("int_cause", 12'h342, 64'h8000_0000_0000_0007);
        tick();
        chk_wr("int_tval", 12'h343, 64'd0);
        tick();
        chk_wr("int_status", 12'h300, 64'h1880);
        tick();
        chk("int_redir_pc", redirect_pc, 64'h8000_101C);
        tick();

        // Exception, interrupt and mret together: exception wins, direct target
        except_wb_except = 1'b1; valid_wb = 1'b1; int_pending = 1'b1; mret_wb = 1'b1;
        except_wb_epc = 64'h8000_0300; except_wb_ecause = 64'd5; except_wb_etval = 64'h44;
        #1;
        tick();
        idle_inputs();
        #1;
        chk_wr("pri_epc", 12'h341, 64'h8000_0300);
        tick();
        chk_wr("pri_cause", 12'h342, 64'd5);
        tick();
        chk_wr("pri_tval", 12'h343, 64'h44);
        tick();
        chk("pri_status_addr", 64'(csr_waddr), 64'h300);
        tick();
        chk("pri_redir_pc", redirect_pc, 64'h8000_1000);
        tick();

        // Bubble: except without valid_wb
        except_wb_except = 1'b1; valid_wb = 1'b0;
        #1;
        chk("bub_stall", 64'(stall_pipe), 64'd0);
        chk("bub_flush", 64'(flush_all), 64'd0);
        tick();
        chk("bub_busy", 64'(trap_busy), 64'd0);
        chk("bub_we", 64'(csr_we), 64'd0);
        idle_inputs();

        // Drop to priv 0 via mret, then reset during W_TVAL
        mstatus_i = 64'h80; mepc_i = 64'h8000_0500;
        valid_wb = 1'b1; mret_wb = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("pre_rst_priv", 64'(priv_o), 64'd0);
        except_wb_except = 1'b1; valid_wb = 1'b1;
        except_wb_epc = 64'h8000_0600; except_wb_ecause = 64'd3;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("mid_tval_addr", 64'(csr_waddr), 64'h343);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(trap_busy), 64'd0);
        chk("mid_rst_priv", 64'(priv_o), 64'd3);
        chk("mid_rst_we", 64'(csr_we), 64'd0);
        chk("mid_rst_stall", 64'(stall_pipe), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_redir", 64'(redirect_valid), 64'd0);
        tick();
        chk("post_rst_redir2", 64'(redirect_valid), 64'd0);
        chk("post_rst_busy", 64'(trap_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_commit_unit.md
Name: trap_commit_unit

Overview:
- Consumer end of the exception-pack protocol. Receives the ExceptPack that the ID/EXE/MEM checkers carry down the pipeline, plus mret and pending interrupts, at writeback.
- Sequences the machine-mode trap CSR writes over a single CSR write port, updates privilege, then redirects the PC and flushes the pipeline.
- Sits between the WB stage, the CSR file and the PC-select logic.

Parameters:
- XLEN, 64, data/address width
- MTVEC_VEC_EN, 1, 1 = honour mtvec.MODE=1 (vectored) for interrupts; 0 = always direct

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- except_wb  in  ExceptStruct::ExceptPack  fields except, epc, ecause, etval of the retiring instruction
- valid_wb  in  1  WB slot holds a real instruction
- mret_wb  in  1  retiring instruction is mret (no exception)
- int_pending  in  1  external/timer interrupt pending and enabled in mie
- int_code  in  4  interrupt cause code
- mstatus_i  in  XLEN  current mstatus
- mtvec_i  in  XLEN  current mtvec
- mepc_i  in  XLEN  current mepc
- csr_we  out  1  CSR write strobe
- csr_waddr  out  12  CSR address: mepc 0x341, mcause 0x342, mtval 0x343, mstatus 0x300
- csr_wdata  out  XLEN  CSR write data
- priv_o  out  2  current privilege level
- stall_pipe  out  1  freeze all stages
- flush_all  out  1  squash IF..WB
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  XLEN  redirect target
- trap_busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, priv_o=2'b11 (M).
  - All strobes and outputs are 0.
  - Latched epc, cause, tval and mstatus registers are 0.
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIRECT.
- Trigger evaluation happens in IDLE only, in priority order:
  1. Exception: valid_wb & except_wb.except. Latch epc, ecause and etval. Go to W_EPC.
  2. Interrupt: int_pending & mstatus_i.MIE(bit 3) & no exception. Latch epc=except_wb.epc (pc of the retiring instruction, which is not executed), cause={1'b1, 59'b0, int_code}, tval=0. Go to W_EPC.
  3. mret: valid_wb & mret_wb & no exception & no interrupt. Go to R_STATUS.
- On any trigger, in the same cycle:
  - stall_pipe=1 and flush_all=1.
  - mstatus_i is snapshotted into a working register.
- While state != IDLE, stall_pipe=1 and trap_busy=1. New triggers are ignored.
- Each write state asserts csr_we=1 for exactly one cycle, then advances to the next state:
  - W_EPC: writes mepc, wdata = {epc[63:2], 2'b00}.
  - W_CAUSE: writes mcause.
  - W_TVAL: writes mtval.
  - W_STATUS: writes mstatus with MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=priv_o; all other bits unchanged. priv_o<=2'b11 on exit.
  - R_STATUS: writes mstatus with MIE<=MPIE, MPIE<=1, MPP<=2'b00. priv_o<=old MPP on exit.
- REDIRECT: redirect_valid=1 and flush_all=1 for one cycle, then IDLE. stall_pipe drops in the IDLE cycle after REDIRECT.
- Redirect target:
  - mret: redirect_pc = mepc_i sampled in REDIRECT.
  - Trap: base = {mtvec_i[63:2], 2'b00}. If cause[63] & MTVEC_VEC_EN & mtvec_i[1:0]==1, redirect_pc = base + 4*cause[3:0]; otherwise redirect_pc = base.
- Latencies (trigger cycle to redirect):
  - Trap: 5 cycles (W_EPC..REDIRECT).
  - mret: 2 cycles.
- valid_wb=0 with except_wb.except=1 is not a trap; the bubble is ignored.
- Reset mid-sequence: returns to IDLE immediately. Partial CSR writes are not undone.
- csr_we is never asserted in IDLE or REDIRECT.
- Arithmetic: the vectored offset is a zero-extended 6-bit value; the add wraps modulo 2^64.

Test Plan:
- Illegal instruction: except_wb={1, epc=0x80000010, ecause=2, etval=0x00000013}, valid_wb=1, priv_o=0, mtvec=0x80001000 -> required response:
  - Writes in order: 0x341<=0x80000010, 0x342<=2, 0x343<=0x13.
  - 0x300 written with MPP=0 and MIE cleared.
  - redirect_pc=0x80001000 exactly 5 cycles after the trigger; priv_o=3.
- Vectored timer interrupt: int_pending=1, int_code=7, MIE=1, mtvec=0x80001001 -> mcause=0x8000000000000007, mtval=0, redirect_pc=0x8000101C.
- Exception and interrupt in the same cycle, plus an mret: except=1, int_pending=1, mret_wb=1 -> exception path taken, mcause = the exception code, no R_STATUS.
- mret: mstatus MPP=0, MPIE=1, mepc=0x80000400 -> mstatus MIE=1, MPIE=1, MPP=0; priv_o=0; redirect_pc=0x80000400 two cycles after the trigger.
- Bubble and busy: except=1 with valid_wb=0 -> no csr_we, no stall. A second exception presented during W_CAUSE is ignored (one sequence only).
- Reset asserted during W_TVAL -> state IDLE, priv_o=3, all strobes 0 in the same cycle (asynchronous), no redirect.
